// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response bundle between the core and the
// load/store unit.
//   master (core side): drives req, mem_write, funct3, addr, write_data;
//                       receives read_data, stall, done, err.
//   slave  (LSU side) : the mirror image.
interface load_store_unit_if;
  logic        req;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output req, mem_write, funct3, addr, write_data,
    input  read_data, stall, done, err
  );

  modport slave (
    input  req, mem_write, funct3, addr, write_data,
    output read_data, stall, done, err
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit with a private word-organised
// data RAM and a configurable number of wait states per access.
//   clk      : clock, all state on the rising edge
//   n_reset  : asynchronous active-low reset (control and read_data only)
//   bus      : load_store_unit_if.slave
//              req/mem_write/funct3/addr/write_data in,
//              read_data (registered), stall (comb), done/err (pulses) out
// Parameters: DEPTH (words, power of 2, >= 4), WAIT_CYCLES (0..15).
// Build option: define LOAD_STORE_UNIT_ERR_EN to enable misalignment /
// illegal-funct3 fault detection; otherwise misaligned accesses are aligned
// down, illegal funct3 codes act as word accesses and err is tied low.
module load_store_unit #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  load_store_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_q;
  logic [AW-1:0] idx;
  logic          fault;
  logic          commit;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic          unused_addr;

  // Byte/half/word selection uses funct3[1:0]; every other code is a word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic signed [31:0] sx;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00: begin
        sx = 32'(signed'(b));
        return f3[2] ? {24'd0, b} : sx;
      end
      2'b01: begin
        sx = 32'(signed'(h));
        return f3[2] ? {16'd0, h} : sx;
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] off,
                                            input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd,
                                             input logic [2:0]  f3);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  assign idx         = bus.addr[AW+1:2];
  assign unused_addr = ^bus.addr[31:AW+2];
  assign wmask       = store_mask(bus.addr[1:0], bus.funct3);
  assign wdata       = store_data(bus.write_data, bus.funct3);

`ifdef LOAD_STORE_UNIT_ERR_EN
  assign fault = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111) ||
                 ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3 == 3'b010) && (bus.addr[1:0] != 2'b00));
`else
  assign fault = 1'b0;
`endif

  // The edge that enters DONE is the single commit point of an access.
  assign commit = (state != DONE) && (state_nxt == DONE);

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (fault || (WAIT_CYCLES == 0)) state_nxt = DONE;
          else                             state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req)      state_nxt = IDLE;  // abandoned access, nothing committed
        else if (cnt == 0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.stall = bus.req && (state != DONE);
    bus.done  = (state == DONE);
  end

  // Wait-state counter: reloaded on every entry into BUSY.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                               cnt <= 4'd0;
    else if (state == IDLE && state_nxt == BUSY) cnt <= CNT_INIT;
    else if (state == BUSY && cnt != 4'd0)       cnt <= cnt - 4'd1;
  end

  // Load capture: only completed loads (or faults) touch read_data.
`ifdef LOAD_STORE_UNIT_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_q  <= 32'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (commit) begin
        if (fault) begin
          rd_q  <= 32'd0;
          err_q <= 1'b1;
        end else if (!bus.mem_write) begin
          rd_q <= load_extend(mem[idx], bus.addr[1:0], bus.funct3);
        end
      end
    end
  end
  assign bus.err = err_q;
`else
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                     rd_q <= 32'd0;
    else if (commit && !bus.mem_write) rd_q <= load_extend(mem[idx], bus.addr[1:0], bus.funct3);
  end
  assign bus.err = 1'b0;
`endif

  assign bus.read_data = rd_q;

  // Data RAM: not reset, byte-lane writes.
  always_ff @(posedge clk) begin
    if (commit && bus.mem_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with WAIT_CYCLES=2 driven from a
// vector table plus hand-written abort/reset sequences, and one instance with
// WAIT_CYCLES=0 for back-to-back accesses. Expected results are queued when
// an access is launched and popped when done is observed.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  load_store_unit_if if2();
  load_store_unit_if if0();

  load_store_unit #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .n_reset(n_reset), .bus(if2)
  );
  load_store_unit #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .n_reset(n_reset), .bus(if0)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check32(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check1(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic checki(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(bit sel, logic r, logic we, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] wd);
    if (sel) begin
      if0.req = r; if0.mem_write = we; if0.funct3 = f3; if0.addr = a; if0.write_data = wd;
    end else begin
      if2.req = r; if2.mem_write = we; if2.funct3 = f3; if2.addr = a; if2.write_data = wd;
    end
  endtask

  function automatic logic get_done(bit sel);
    return sel ? if0.done : if2.done;
  endfunction
  function automatic logic get_stall(bit sel);
    return sel ? if0.stall : if2.stall;
  endfunction
  function automatic logic get_err(bit sel);
    return sel ? if0.err : if2.err;
  endfunction
  function automatic logic [31:0] get_rd(bit sel);
    return sel ? if0.read_data : if2.read_data;
  endfunction

  function automatic void add(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic err, int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.err = err; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Called just after a rising edge with the unit in IDLE; returns just after
  // the edge that leaves DONE, with req still asserted.
  task automatic access(bit sel, string name, logic we, logic [2:0] f3,
                        logic [31:0] a, logic [31:0] wd,
                        logic [31:0] rd, logic err, int lat);
    exp_t e;
    exp_t x;
    bit got;
    got = 1'b0;
    drive(sel, 1'b1, we, f3, a, wd);
    e.rd = rd; e.err = err; e.lat = lat;
    sb_q.push_back(e);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      check1({name, " stall"}, get_stall(sel), n < lat);
      if (get_done(sel)) begin
        x = sb_q.pop_front();
        checki({name, " latency"}, n, x.lat);
        check32({name, " read_data"}, get_rd(sel), x.rd);
        check1({name, " err"}, get_err(sel), x.err);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_done required=done", name);
      void'(sb_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with req high on the slow instance to see comb stall.
    n_reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #12;
    check32("reset read_data", if2.read_data, 32'h0);
    check1("reset done", if2.done, 1'b0);
    check1("reset err", if2.err, 1'b0);
    check1("reset stall req1", if2.stall, 1'b1);
    check1("reset stall req0", if0.stall, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk);
    #1;

    add(1, 3'b010, 32'h8,   32'hDEADBEEF, 32'h00000000, 0, 3);
    add(0, 3'b010, 32'h8,   32'h0,        32'hDEADBEEF, 0, 3);
    add(1, 3'b000, 32'h9,   32'h00000080, 32'hDEADBEEF, 0, 3);
    add(0, 3'b000, 32'h9,   32'h0,        32'hFFFFFF80, 0, 3);
    add(0, 3'b100, 32'h9,   32'h0,        32'h00000080, 0, 3);
    add(0, 3'b010, 32'h8,   32'h0,        32'hDEAD80EF, 0, 3);
    add(1, 3'b001, 32'hA,   32'h00001234, 32'hDEAD80EF, 0, 3);
    add(0, 3'b001, 32'hA,   32'h0,        32'h00001234, 0, 3);
    add(0, 3'b010, 32'h8,   32'h0,        32'h123480EF, 0, 3);
    add(1, 3'b010, 32'h4,   32'hCAFEF00D, 32'h123480EF, 0, 3);
    add(0, 3'b101, 32'h6,   32'h0,        32'h0000CAFE, 0, 3);
    add(0, 3'b001, 32'h6,   32'h0,        32'hFFFFCAFE, 0, 3);
    add(0, 3'b000, 32'h7,   32'h0,        32'hFFFFFFCA, 0, 3);
    add(0, 3'b100, 32'h4,   32'h0,        32'h0000000D, 0, 3);
    add(1, 3'b010, 32'h100, 32'h11223344, 32'h0000000D, 0, 3);
    add(0, 3'b010, 32'h0,   32'h0,        32'h11223344, 0, 3);
`ifdef LOAD_STORE_UNIT_ERR_EN
    add(0, 3'b010, 32'h6,   32'h0,        32'h00000000, 1, 1);
    add(1, 3'b010, 32'h5,   32'hFFFFFFFF, 32'h00000000, 1, 1);
    add(0, 3'b011, 32'h8,   32'h0,        32'h00000000, 1, 1);
    add(0, 3'b001, 32'h9,   32'h0,        32'h00000000, 1, 1);
`else
    add(0, 3'b010, 32'h6,   32'h0,        32'hCAFEF00D, 0, 3);
    add(0, 3'b011, 32'h8,   32'h0,        32'h123480EF, 0, 3);
    add(0, 3'b001, 32'h9,   32'h0,        32'hFFFF80EF, 0, 3);
`endif
    add(0, 3'b010, 32'h8,   32'h0,        32'h123480EF, 0, 3);
    add(0, 3'b010, 32'h4,   32'h0,        32'hCAFEF00D, 0, 3);

    foreach (vecs[i]) begin
      access(1'b0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
             vecs[i].wd, vecs[i].rd, vecs[i].err, vecs[i].lat);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    check1("done single pulse", if2.done, 1'b0);
    @(posedge clk);
    #1;

    // Store abandoned in its first BUSY cycle.
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h8, 32'h55555555);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h8, 32'h55555555);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check1($sformatf("abort no done c%0d", n), if2.done, 1'b0);
    end
    @(posedge clk);
    #1;
    access(1'b0, "abort ram kept", 1'b0, 3'b010, 32'h8, 32'h0, 32'h123480EF, 1'b0, 3);
    access(1'b0, "abort reload", 1'b0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    // Reset in the middle of a store.
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h8, 32'hAAAAAAAA);
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check32("midreset read_data", if2.read_data, 32'h0);
    check1("midreset done", if2.done, 1'b0);
    check1("midreset err", if2.err, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h8, 32'hAAAAAAAA);
    #1;
    check1("midreset stall", if2.stall, 1'b0);
    @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, "after reset", 1'b0, 3'b010, 32'h8, 32'h0, 32'h123480EF, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

    // Zero wait states, back-to-back pairs.
    access(1'b1, "w0 sw10", 1'b1, 3'b010, 32'h10,  32'h01020304, 32'h00000000, 1'b0, 1);
    access(1'b1, "w0 lw10", 1'b0, 3'b010, 32'h10,  32'h0,        32'h01020304, 1'b0, 1);
    access(1'b1, "w0 sw14", 1'b1, 3'b010, 32'h14,  32'hA5A5A5A5, 32'h01020304, 1'b0, 1);
    access(1'b1, "w0 lw114", 1'b0, 3'b010, 32'h114, 32'h0,       32'hA5A5A5A5, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    check1("w0 idle done", if0.done, 1'b0);

    checki("scoreboard empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
